// File: rtl/lpm_table_arbiter_if.sv
// Management port of the LPM route table: read and write request/ack
// channels. The arbiter drives it as master; the table side is the slave.
interface lpm_table_arbiter_if #(
  parameter int NUM_QUEUES     = 5,
  parameter int LUT_DEPTH_BITS = 5
) ();
  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr;
  logic                      lpm_rd_req;
  logic [31:0]               lpm_rd_ip;
  logic [31:0]               lpm_rd_mask;
  logic [31:0]               lpm_rd_next_hop_ip;
  logic [NUM_QUEUES-1:0]     lpm_rd_oq;
  logic                      lpm_rd_ack;
  logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr;
  logic                      lpm_wr_req;
  logic [31:0]               lpm_wr_ip;
  logic [31:0]               lpm_wr_mask;
  logic [31:0]               lpm_wr_next_hop_ip;
  logic [NUM_QUEUES-1:0]     lpm_wr_oq;
  logic                      lpm_wr_ack;

  modport master (
    output lpm_rd_addr, lpm_rd_req,
    input  lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_ack,
    output lpm_wr_addr, lpm_wr_req, lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    input  lpm_wr_ack
  );

  modport slave (
    input  lpm_rd_addr, lpm_rd_req,
    output lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip, lpm_rd_oq, lpm_rd_ack,
    input  lpm_wr_addr, lpm_wr_req, lpm_wr_ip, lpm_wr_mask, lpm_wr_next_hop_ip, lpm_wr_oq,
    output lpm_wr_ack
  );
endinterface

// File: rtl/lpm_table_arbiter.sv
// Round-robin arbiter sharing the LPM table management port among several
// clients, with one operation in flight, an ack timeout on every operation
// and a built-in sequencer that rewrites every entry to the empty route.
module lpm_table_arbiter #(
  parameter int NUM_CLIENTS    = 2,
  parameter int NUM_QUEUES     = 5,
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int TIMEOUT        = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CLIENTS-1:0]                 client_req,
  input  logic [NUM_CLIENTS-1:0]                 client_wr,
  input  logic [NUM_CLIENTS*LUT_DEPTH_BITS-1:0]  client_addr,
  input  logic [NUM_CLIENTS*(96+NUM_QUEUES)-1:0] client_wr_data,
  output logic [NUM_CLIENTS-1:0]                 client_ack,
  output logic                                   client_err,
  output logic [31:0]                            rd_ip,
  output logic [31:0]                            rd_mask,
  output logic [31:0]                            rd_next_hop_ip,
  output logic [NUM_QUEUES-1:0]                  rd_oq,
  input  logic                                   clear_req,
  output logic                                   clear_busy,
  output logic                                   clear_done,
  lpm_table_arbiter_if.master                    lpm
);
  localparam int DW = 96 + NUM_QUEUES;
  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]             LAST_CLIENT = GW'(NUM_CLIENTS - 1);
  localparam logic [CW-1:0]             TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [CW-1:0]             CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [LUT_DEPTH_BITS-1:0] LAST_ADDR   = LUT_DEPTH_BITS'(LUT_DEPTH - 1);
  localparam logic [LUT_DEPTH_BITS-1:0] ADDR_ONE    = {{(LUT_DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_CLIENTS-1:0]    CLIENT0_BIT = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_CLR_WR   = 3'd3,
    S_CLR_WAIT = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [GW-1:0]             last_grant_q, last_grant_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LUT_DEPTH_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                      clear_pending_q, clear_pending_d;
  logic                      clear_done_q, clear_done_d;
  logic [NUM_CLIENTS-1:0]    client_ack_q, client_ack_d;
  logic                      client_err_q, client_err_d;
  logic [31:0]               rd_ip_q, rd_ip_d, rd_mask_q, rd_mask_d, rd_nh_q, rd_nh_d;
  logic [NUM_QUEUES-1:0]     rd_oq_q, rd_oq_d;
  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr_q, lpm_rd_addr_d, lpm_wr_addr_q, lpm_wr_addr_d;
  logic                      lpm_rd_req_q, lpm_rd_req_d, lpm_wr_req_q, lpm_wr_req_d;
  logic [31:0]               wr_ip_q, wr_ip_d, wr_mask_q, wr_mask_d, wr_nh_q, wr_nh_d;
  logic [NUM_QUEUES-1:0]     wr_oq_q, wr_oq_d;

  logic                      rr_found_s;
  logic [GW-1:0]             rr_idx_s;
  logic [GW-1:0]             rr_cand_s;
  logic [LUT_DEPTH_BITS-1:0] sel_addr_s;
  logic [DW-1:0]             sel_data_s;

  assign sel_addr_s = client_addr[int'(rr_idx_s)*LUT_DEPTH_BITS +: LUT_DEPTH_BITS];
  assign sel_data_s = client_wr_data[int'(rr_idx_s)*DW +: DW];

  // Round-robin pick: first requester after the last granted client.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    rr_cand_s  = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      rr_cand_s  = GW'((int'(last_grant_q) + k) % NUM_CLIENTS);
      rr_idx_s   = (!rr_found_s && client_req[rr_cand_s]) ? rr_cand_s : rr_idx_s;
      rr_found_s = rr_found_s | client_req[rr_cand_s];
    end
  end

  // Next-state, pulse and datapath computation for the arbiter/clear FSM.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    clr_addr_d      = clr_addr_q;
    clear_pending_d = clear_pending_q | clear_req;
    clear_done_d    = 1'b0;
    client_ack_d    = '0;
    client_err_d    = 1'b0;
    rd_ip_d         = rd_ip_q;
    rd_mask_d       = rd_mask_q;
    rd_nh_d         = rd_nh_q;
    rd_oq_d         = rd_oq_q;
    lpm_rd_addr_d   = lpm_rd_addr_q;
    lpm_wr_addr_d   = lpm_wr_addr_q;
    lpm_rd_req_d    = 1'b0;
    lpm_wr_req_d    = 1'b0;
    wr_ip_d         = wr_ip_q;
    wr_mask_d       = wr_mask_q;
    wr_nh_d         = wr_nh_q;
    wr_oq_d         = wr_oq_q;

    case (state_q)
      S_IDLE: begin
        if (clear_pending_q) begin
          clr_addr_d = '0;
          state_d    = S_CLR_WR;
        end else if (rr_found_s) begin
          grant_d      = rr_idx_s;
          last_grant_d = rr_idx_s;
          cnt_d        = '0;
          if (client_wr[rr_idx_s]) begin
            lpm_wr_req_d  = 1'b1;
            lpm_wr_addr_d = sel_addr_s;
            wr_mask_d     = sel_data_s[31:0];
            wr_ip_d       = sel_data_s[63:32];
            wr_nh_d       = sel_data_s[95:64];
            wr_oq_d       = sel_data_s[DW-1:96];
            state_d       = S_WR_WAIT;
          end else begin
            lpm_rd_req_d  = 1'b1;
            lpm_rd_addr_d = sel_addr_s;
            state_d       = S_RD_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD_WAIT: begin
        if (lpm.lpm_rd_ack) begin
          client_ack_d = CLIENT0_BIT << grant_q;
          rd_ip_d      = lpm.lpm_rd_ip;
          rd_mask_d    = lpm.lpm_rd_mask;
          rd_nh_d      = lpm.lpm_rd_next_hop_ip;
          rd_oq_d      = lpm.lpm_rd_oq;
          state_d      = S_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          client_ack_d = CLIENT0_BIT << grant_q;
          client_err_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WR_WAIT: begin
        if (lpm.lpm_wr_ack) begin
          client_ack_d = CLIENT0_BIT << grant_q;
          state_d      = S_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          client_ack_d = CLIENT0_BIT << grant_q;
          client_err_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_CLR_WR: begin
        lpm_wr_req_d  = 1'b1;
        lpm_wr_addr_d = clr_addr_q;
        wr_ip_d       = 32'h0000_0000;
        wr_mask_d     = 32'hFFFF_FFFF;
        wr_nh_d       = 32'h0000_0000;
        wr_oq_d       = {NUM_QUEUES{1'b0}};
        cnt_d         = '0;
        state_d       = S_CLR_WAIT;
      end

      S_CLR_WAIT: begin
        // A timed-out entry is skipped without any report.
        if (lpm.lpm_wr_ack || (cnt_q == TIMEOUT_CNT)) begin
          if (clr_addr_q == LAST_ADDR) begin
            clear_done_d    = 1'b1;
            clear_pending_d = 1'b0;
            state_d         = S_IDLE;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_ONE;
            state_d    = S_CLR_WR;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      last_grant_q    <= LAST_CLIENT;
      grant_q         <= '0;
      cnt_q           <= '0;
      clr_addr_q      <= '0;
      clear_pending_q <= 1'b0;
      clear_done_q    <= 1'b0;
      client_ack_q    <= '0;
      client_err_q    <= 1'b0;
      rd_ip_q         <= 32'h0000_0000;
      rd_mask_q       <= 32'h0000_0000;
      rd_nh_q         <= 32'h0000_0000;
      rd_oq_q         <= '0;
      lpm_rd_addr_q   <= '0;
      lpm_wr_addr_q   <= '0;
      lpm_rd_req_q    <= 1'b0;
      lpm_wr_req_q    <= 1'b0;
      wr_ip_q         <= 32'h0000_0000;
      wr_mask_q       <= 32'h0000_0000;
      wr_nh_q         <= 32'h0000_0000;
      wr_oq_q         <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_q         <= grant_d;
      cnt_q           <= cnt_d;
      clr_addr_q      <= clr_addr_d;
      clear_pending_q <= clear_pending_d;
      clear_done_q    <= clear_done_d;
      client_ack_q    <= client_ack_d;
      client_err_q    <= client_err_d;
      rd_ip_q         <= rd_ip_d;
      rd_mask_q       <= rd_mask_d;
      rd_nh_q         <= rd_nh_d;
      rd_oq_q         <= rd_oq_d;
      lpm_rd_addr_q   <= lpm_rd_addr_d;
      lpm_wr_addr_q   <= lpm_wr_addr_d;
      lpm_rd_req_q    <= lpm_rd_req_d;
      lpm_wr_req_q    <= lpm_wr_req_d;
      wr_ip_q         <= wr_ip_d;
      wr_mask_q       <= wr_mask_d;
      wr_nh_q         <= wr_nh_d;
      wr_oq_q         <= wr_oq_d;
    end
  end

  assign client_ack             = client_ack_q;
  assign client_err             = client_err_q;
  assign rd_ip                  = rd_ip_q;
  assign rd_mask                = rd_mask_q;
  assign rd_next_hop_ip         = rd_nh_q;
  assign rd_oq                  = rd_oq_q;
  assign clear_busy             = clear_pending_q;
  assign clear_done             = clear_done_q;
  assign lpm.lpm_rd_addr        = lpm_rd_addr_q;
  assign lpm.lpm_rd_req         = lpm_rd_req_q;
  assign lpm.lpm_wr_addr        = lpm_wr_addr_q;
  assign lpm.lpm_wr_req         = lpm_wr_req_q;
  assign lpm.lpm_wr_ip          = wr_ip_q;
  assign lpm.lpm_wr_mask        = wr_mask_q;
  assign lpm.lpm_wr_next_hop_ip = wr_nh_q;
  assign lpm.lpm_wr_oq          = wr_oq_q;
endmodule

// File: tb/tb_lpm_table_arbiter.sv
// Directed bench for lpm_table_arbiter: the table side is driven by hand
// from the stimulus tasks and every expected value is fixed in the task.
module tb_lpm_table_arbiter;
  localparam int NC = 2;
  localparam int NQ = 5;
  localparam int LD = 32;
  localparam int LB = 5;
  localparam int TO = 64;
  localparam int DW = 96 + NQ;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    client_req, client_wr;
  logic [NC*LB-1:0] client_addr;
  logic [NC*DW-1:0] client_wr_data;
  logic [NC-1:0]    client_ack;
  logic             client_err;
  logic [31:0]      rd_ip, rd_mask, rd_next_hop_ip;
  logic [NQ-1:0]    rd_oq;
  logic             clear_req, clear_busy, clear_done;
  logic             any_out;
  int               checks = 0;
  int               errors = 0;

  lpm_table_arbiter_if #(.NUM_QUEUES(NQ), .LUT_DEPTH_BITS(LB)) lpm_if ();

  lpm_table_arbiter #(
    .NUM_CLIENTS(NC), .NUM_QUEUES(NQ), .LUT_DEPTH(LD), .LUT_DEPTH_BITS(LB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .client_req(client_req), .client_wr(client_wr),
    .client_addr(client_addr), .client_wr_data(client_wr_data),
    .client_ack(client_ack), .client_err(client_err),
    .rd_ip(rd_ip), .rd_mask(rd_mask), .rd_next_hop_ip(rd_next_hop_ip), .rd_oq(rd_oq),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .lpm(lpm_if)
  );

  always #5 clk = ~clk;

  assign any_out = |{client_ack, client_err, rd_ip, rd_mask, rd_next_hop_ip, rd_oq,
                     clear_busy, clear_done, lpm_if.lpm_rd_addr, lpm_if.lpm_rd_req,
                     lpm_if.lpm_wr_addr, lpm_if.lpm_wr_req, lpm_if.lpm_wr_ip,
                     lpm_if.lpm_wr_mask, lpm_if.lpm_wr_next_hop_ip, lpm_if.lpm_wr_oq};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int c, input logic wr, input logic [LB-1:0] addr,
                            input logic [DW-1:0] data);
    client_wr[c]             = wr;
    client_addr[c*LB +: LB]  = addr;
    client_wr_data[c*DW +: DW] = data;
  endtask

  task automatic set_rd_data(input logic [31:0] ip, input logic [31:0] mask,
                             input logic [31:0] nh, input logic [NQ-1:0] oq);
    lpm_if.lpm_rd_ip          = ip;
    lpm_if.lpm_rd_mask        = mask;
    lpm_if.lpm_rd_next_hop_ip = nh;
    lpm_if.lpm_rd_oq          = oq;
  endtask

  // Ticks until a table request pulse is visible; n = -1 if none within 20 cycles.
  task automatic wait_table_req(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (lpm_if.lpm_rd_req !== 1'b1 && lpm_if.lpm_wr_req !== 1'b1 && n < 20);
    if (lpm_if.lpm_rd_req !== 1'b1 && lpm_if.lpm_wr_req !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs actual any_out=%b required 0", any_out);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [LB-1:0] exp_addr;
    logic [NC-1:0] exp_ack;
    set_client(0, 1'b0, 5'd5, '0);
    set_client(1, 1'b0, 5'd9, '0);
    client_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      exp_addr = (i % 2 == 1) ? 5'd9 : 5'd5;
      exp_ack  = (i % 2 == 1) ? 2'b10 : 2'b01;
      wait_table_req(n);
      checks++;
      if (n < 0 || lpm_if.lpm_rd_req !== 1'b1 || lpm_if.lpm_rd_addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_grant op %0d actual req=%b addr=%0d required req=1 addr=%0d",
                 i, lpm_if.lpm_rd_req, lpm_if.lpm_rd_addr, exp_addr);
      end
      tick();
      checks++;
      if (lpm_if.lpm_rd_req !== 1'b0 || lpm_if.lpm_wr_req !== 1'b0) begin
        errors++;
        $display("FAIL rr_outstanding op %0d actual rd_req=%b wr_req=%b required 0 0",
                 i, lpm_if.lpm_rd_req, lpm_if.lpm_wr_req);
      end
      lpm_if.lpm_rd_ack = 1'b1;
      tick();
      lpm_if.lpm_rd_ack = 1'b0;
      if (i == 5) client_req = 2'b00;
      checks++;
      if (client_ack !== exp_ack || client_err !== 1'b0) begin
        errors++;
        $display("FAIL rr_ack op %0d actual ack=%b err=%b required ack=%b err=0",
                 i, client_ack, client_err, exp_ack);
      end
    end
  endtask

  task automatic test_single_read();
    set_client(0, 1'b0, 5'd3, '0);
    client_req = 2'b01;
    tick();
    checks++;
    if (lpm_if.lpm_rd_req !== 1'b1 || lpm_if.lpm_rd_addr !== 5'd3) begin
      errors++;
      $display("FAIL read_req actual req=%b addr=%0d required req=1 addr=3",
               lpm_if.lpm_rd_req, lpm_if.lpm_rd_addr);
    end
    tick();
    tick();
    checks++;
    if (lpm_if.lpm_rd_req !== 1'b0 || client_ack !== 2'b00) begin
      errors++;
      $display("FAIL read_wait actual req=%b ack=%b required 0 00", lpm_if.lpm_rd_req, client_ack);
    end
    set_rd_data(32'hC0A8_0001, 32'hFFFF_FF00, 32'h0A00_0001, 5'h15);
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_rd_ack = 1'b0;
    client_req = 2'b00;
    checks++;
    if (client_ack !== 2'b01 || client_err !== 1'b0) begin
      errors++;
      $display("FAIL read_ack actual ack=%b err=%b required 01 0", client_ack, client_err);
    end
    checks++;
    if (rd_ip !== 32'hC0A8_0001 || rd_mask !== 32'hFFFF_FF00 ||
        rd_next_hop_ip !== 32'h0A00_0001 || rd_oq !== 5'h15) begin
      errors++;
      $display("FAIL read_data actual %h %h %h %h required c0a80001 ffffff00 0a000001 15",
               rd_ip, rd_mask, rd_next_hop_ip, rd_oq);
    end
    tick();
    checks++;
    if (client_ack !== 2'b00) begin
      errors++;
      $display("FAIL read_ack_pulse actual ack=%b required 00", client_ack);
    end
  endtask

  task automatic test_timeout();
    int n;
    set_client(1, 1'b1, 5'd7, {5'h0A, 32'h0B0B_0B0B, 32'h0A0A_0A00, 32'hFFFF_FF00});
    client_req = 2'b10;
    tick();
    n = 1;
    checks++;
    if (lpm_if.lpm_wr_req !== 1'b1 || lpm_if.lpm_wr_addr !== 5'd7 ||
        lpm_if.lpm_wr_ip !== 32'h0A0A_0A00 || lpm_if.lpm_wr_mask !== 32'hFFFF_FF00 ||
        lpm_if.lpm_wr_next_hop_ip !== 32'h0B0B_0B0B || lpm_if.lpm_wr_oq !== 5'h0A) begin
      errors++;
      $display("FAIL write_req actual req=%b addr=%0d ip=%h mask=%h nh=%h oq=%h",
               lpm_if.lpm_wr_req, lpm_if.lpm_wr_addr, lpm_if.lpm_wr_ip,
               lpm_if.lpm_wr_mask, lpm_if.lpm_wr_next_hop_ip, lpm_if.lpm_wr_oq);
    end
    while (client_ack === 2'b00 && n < TO + 10) begin
      tick();
      n++;
    end
    client_req = 2'b00;
    checks++;
    if (n != TO + 2 || client_ack !== 2'b10 || client_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout actual cycle=%0d ack=%b err=%b required cycle=%0d ack=10 err=1",
               n, client_ack, client_err, TO + 2);
    end
    checks++;
    if (rd_ip !== 32'hC0A8_0001) begin
      errors++;
      $display("FAIL timeout_rd_hold actual rd_ip=%h required c0a80001", rd_ip);
    end
    lpm_if.lpm_wr_ack = 1'b1;
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_wr_ack = 1'b0;
    lpm_if.lpm_rd_ack = 1'b0;
    tick();
    checks++;
    if (client_ack !== 2'b00 || client_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack actual ack=%b err=%b required 00 0", client_ack, client_err);
    end
  endtask

  task automatic test_timeout_boundary();
    int n;
    int early;
    early = 0;
    set_client(0, 1'b0, 5'd12, '0);
    client_req = 2'b01;
    tick();
    n = 1;
    while (n < TO + 1) begin
      tick();
      n++;
      if (client_ack !== 2'b00) early++;
    end
    set_rd_data(32'h0102_0304, 32'hFFFF_0000, 32'h0506_0708, 5'h03);
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_rd_ack = 1'b0;
    client_req = 2'b00;
    checks++;
    if (early != 0 || client_ack !== 2'b01 || client_err !== 1'b0) begin
      errors++;
      $display("FAIL boundary_ack actual early=%0d ack=%b err=%b required 0 01 0",
               early, client_ack, client_err);
    end
    checks++;
    if (rd_ip !== 32'h0102_0304 || rd_oq !== 5'h03) begin
      errors++;
      $display("FAIL boundary_data actual ip=%h oq=%h required 01020304 03", rd_ip, rd_oq);
    end
  endtask

  task automatic test_clear_precedence();
    int n;
    int stray;
    int done_cnt;
    stray    = 0;
    done_cnt = 0;
    set_client(0, 1'b0, 5'd2, '0);
    client_req = 2'b01;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (clear_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy actual %b required 1", clear_busy);
    end
    set_rd_data(32'hAABB_CCDD, 32'hFFFF_FFF0, 32'h1111_2222, 5'h1F);
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_rd_ack = 1'b0;
    checks++;
    if (client_ack !== 2'b01 || rd_ip !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL clear_read_done actual ack=%b ip=%h required 01 aabbccdd", client_ack, rd_ip);
    end
    for (int e = 0; e < LD; e++) begin
      n = 0;
      while (lpm_if.lpm_wr_req !== 1'b1 && n < 10) begin
        tick();
        n++;
        if (lpm_if.lpm_rd_req === 1'b1 || client_ack !== 2'b00) stray++;
        if (clear_done === 1'b1) done_cnt++;
      end
      checks++;
      if (lpm_if.lpm_wr_req !== 1'b1 || lpm_if.lpm_wr_addr !== e[LB-1:0] ||
          lpm_if.lpm_wr_ip !== 32'h0 || lpm_if.lpm_wr_mask !== 32'hFFFF_FFFF ||
          lpm_if.lpm_wr_next_hop_ip !== 32'h0 || lpm_if.lpm_wr_oq !== 5'h00) begin
        errors++;
        $display("FAIL clear_entry %0d actual req=%b addr=%0d ip=%h mask=%h nh=%h oq=%h",
                 e, lpm_if.lpm_wr_req, lpm_if.lpm_wr_addr, lpm_if.lpm_wr_ip,
                 lpm_if.lpm_wr_mask, lpm_if.lpm_wr_next_hop_ip, lpm_if.lpm_wr_oq);
        break;
      end
      lpm_if.lpm_wr_ack = 1'b1;
      tick();
      lpm_if.lpm_wr_ack = 1'b0;
      if (client_ack !== 2'b00) stray++;
      if (clear_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 1 || stray != 0 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done actual pulses=%0d stray=%0d busy=%b required 1 0 0",
               done_cnt, stray, clear_busy);
    end
    tick();
    checks++;
    if (lpm_if.lpm_rd_req !== 1'b1 || lpm_if.lpm_rd_addr !== 5'd2 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_then_client actual req=%b addr=%0d done=%b required 1 2 0",
               lpm_if.lpm_rd_req, lpm_if.lpm_rd_addr, clear_done);
    end
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_rd_ack = 1'b0;
    client_req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int n;
    set_client(0, 1'b1, 5'd4, {5'h07, 32'h0909_0909, 32'h0808_0800, 32'hFFFF_FF00});
    client_req = 2'b01;
    tick();
    tick();
    reset = 1'b1;
    client_req = 2'b00;
    tick();
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_wait actual any_out=%b required 0", any_out);
    end
    tick();
    reset = 1'b0;
    lpm_if.lpm_wr_ack = 1'b1;
    tick();
    lpm_if.lpm_wr_ack = 1'b0;
    tick();
    checks++;
    if (client_ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_ack actual ack=%b required 00", client_ack);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      wait_table_req(n);
      checks++;
      if (n < 0 || lpm_if.lpm_wr_addr !== e[LB-1:0]) begin
        errors++;
        $display("FAIL reset_clear_entry %0d actual found=%0d addr=%0d required addr=%0d",
                 e, n, lpm_if.lpm_wr_addr, e);
        break;
      end
      if (e < 10) begin
        lpm_if.lpm_wr_ack = 1'b1;
        tick();
        lpm_if.lpm_wr_ack = 1'b0;
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_clear actual any_out=%b required 0", any_out);
    end
    tick();
    reset = 1'b0;
    set_client(0, 1'b0, 5'd1, '0);
    set_client(1, 1'b0, 5'd30, '0);
    client_req = 2'b11;
    tick();
    checks++;
    if (lpm_if.lpm_rd_req !== 1'b1 || lpm_if.lpm_rd_addr !== 5'd1 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant actual req=%b addr=%0d busy=%b required 1 1 0",
               lpm_if.lpm_rd_req, lpm_if.lpm_rd_addr, clear_busy);
    end
    client_req = 2'b10;
    lpm_if.lpm_rd_ack = 1'b1;
    tick();
    lpm_if.lpm_rd_ack = 1'b0;
    client_req = 2'b00;
    checks++;
    if (client_ack !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_ack actual ack=%b required 01", client_ack);
    end
  endtask

  initial begin
    reset          = 1'b1;
    client_req     = '0;
    client_wr      = '0;
    client_addr    = '0;
    client_wr_data = '0;
    clear_req      = 1'b0;
    lpm_if.lpm_rd_ack = 1'b0;
    lpm_if.lpm_wr_ack = 1'b0;
    set_rd_data(32'h0, 32'h0, 32'h0, 5'h00);
    test_reset();
    test_round_robin();
    test_single_read();
    test_timeout();
    test_timeout_boundary();
    test_clear_precedence();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpm_table_arbiter.md
# lpm_table_arbiter

Shares the single read/write management port of the LPM route table among `NUM_CLIENTS` requesters, such as the host register block and a route-update engine. Clients are served round-robin, with one table operation outstanding at a time. Every operation is guarded by an ack timeout. A built-in clear sequencer rewrites every table entry to a known empty value. The block sits between the register/control clients and the LPM lookup unit's `lpm_rd_*`/`lpm_wr_*` ports.

## Interface
- `NUM_CLIENTS`, 2: number of requesters.
- `NUM_QUEUES`, 5: output-queue bitmap width.
- `LUT_DEPTH`, 32: number of table entries.
- `LUT_DEPTH_BITS`, log2(`LUT_DEPTH`): table address width.
- `TIMEOUT`, 64: cycles to wait for a table ack before aborting.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `client_req` in `NUM_CLIENTS`: per-client request. Held high, with fields stable, until that client's ack.
- `client_wr` in `NUM_CLIENTS`: 1 = write, 0 = read.
- `client_addr` in `NUM_CLIENTS`*`LUT_DEPTH_BITS`: packed entry addresses; client i occupies slice i.
- `client_wr_data` in `NUM_CLIENTS`*(96+`NUM_QUEUES`): packed {oq, next_hop_ip, ip, mask} per client.
- `client_ack` out `NUM_CLIENTS`: one-cycle completion pulse.
- `client_err` out 1: qualifies `client_ack`; 1 = timed out.
- `rd_ip`, `rd_mask`, `rd_next_hop_ip` out 32 each: read result, valid with `client_ack` of a read.
- `rd_oq` out `NUM_QUEUES`: read result, valid with `client_ack` of a read.
- `clear_req` in 1: pulse; request a full-table clear.
- `clear_busy` out 1: clear pending or in progress.
- `clear_done` out 1: one-cycle pulse when the clear finishes.
- `lpm_rd_addr`, `lpm_wr_addr` out `LUT_DEPTH_BITS`: table read/write addresses.
- `lpm_rd_req`, `lpm_wr_req` out 1: one-cycle table request pulses.
- `lpm_wr_ip`, `lpm_wr_mask`, `lpm_wr_next_hop_ip` out 32 each: table write data.
- `lpm_wr_oq` out `NUM_QUEUES`: table write data.
- `lpm_rd_ip`, `lpm_rd_mask`, `lpm_rd_next_hop_ip` in 32 each: table read data.
- `lpm_rd_oq` in `NUM_QUEUES`: table read data.
- `lpm_rd_ack`, `lpm_wr_ack` in 1: table completion pulses.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, CLR_WR, CLR_WAIT.

**IDLE**
- Priority: `clear_pending`, then round-robin among asserted `client_req`.
- Round-robin search starts at `last_grant`+1 modulo `NUM_CLIENTS`.
- `last_grant` resets to `NUM_CLIENTS`-1, so client 0 wins first.
- On grant, the block registers the client index and the address/data, pulses `lpm_rd_req` or `lpm_wr_req`, and enters RD_WAIT or WR_WAIT.

**RD_WAIT / WR_WAIT**
- The timeout counter (cleared on entry) increments each cycle.
- On the matching ack: pulse `client_ack[g]` with `client_err`=0. For reads, latch `lpm_rd_*` into `rd_*`. Return to IDLE.
- When the counter reaches `TIMEOUT` with no ack: pulse `client_ack[g]` and `client_err`=1, return to IDLE, and leave `rd_*` unchanged.
- An ack on the same cycle the counter reaches `TIMEOUT` counts as success.

**Clear sequencer**
- A `clear_req` pulse sets `clear_pending`. `clear_req` while `clear_busy` is ignored.
- CLR_WR pulses `lpm_wr_req` at `clr_addr` with ip=0, mask=0xFFFFFFFF, next_hop=0, oq=0, then enters CLR_WAIT.
- CLR_WAIT advances on ack or on timeout. A timeout skips the entry silently.
- `clr_addr` runs 0 to `LUT_DEPTH`-1. After the last entry: pulse `clear_done`, clear `clear_pending`, go to IDLE.
- Client requests stall (no ack) for the whole clear.

**General rules**
- Stray or late acks seen in IDLE or CLR_WR are ignored.
- Table address/data outputs hold their values from the request pulse until the next grant.
- Reset aborts any operation. All outputs go to 0 (`rd_*` and `lpm_*` data included), state goes to IDLE, and `clear_pending` is dropped.

## Timing
- A request sampled in IDLE at cycle t gives `lpm_*_req` high at t+1.
- A table ack at cycle a gives `client_ack` at a+1. The state is IDLE at a+1, so the next grant's `lpm_*_req` is at a+2 at the earliest.
- Timeout: `client_ack` with `client_err` at t+1+`TIMEOUT`+1.
- Clear: at most 2 cycles per entry, plus ack latency, plus 1 cycle for `clear_done`.
- `client_ack`, `client_err`, `clear_done`, and `lpm_*_req` are registered single-cycle pulses.

## Test plan
- **Single read:** client 0 reads addr 3 and the table acks 2 cycles after the request. Required: `lpm_rd_req` one cycle after sampling; `client_ack`=01 one cycle after `lpm_rd_ack`; `rd_ip`/`rd_mask`/`rd_oq`/`rd_next_hop_ip` equal the table data; `client_err`=0.
- **Round-robin fairness:** both clients hold `req` continuously for 6 operations. Required: grant order 0,1,0,1,0,1 and never two `lpm_*_req` without an intervening ack.
- **Timeout:** the table never acks a write from client 1. Required: `client_ack`=10 with `client_err`=1 exactly `TIMEOUT`+2 cycles after sampling; an ack injected later in IDLE causes no `client_ack`.
- **Clear precedence:** `clear_req` is pulsed while client 0 is mid-read. Required: the read completes; then all 32 entries are written in address order with ip=0 and mask=FFFFFFFF; `clear_done` pulses once; client 0's next request is served only after that.
- **Ack on the timeout boundary:** ack arrives on the cycle the counter reaches `TIMEOUT`. Required: success ack with `client_err`=0.
- **Reset mid-operation:** `reset` asserted during WR_WAIT and during a clear at addr 10. Required: all outputs 0 the next cycle, no ack pulses, and client 0 is the first grant after reset.
